// File: rtl/rng_pkg.sv
// Shared constants and FSM encoding for the RNG word buffer.
// Defaults describe a 512-bit digest split into 32-bit words over a 1K-word store.
package rng_pkg;

    localparam int DIGEST_W_DEF = 512;
    localparam int WORD_W_DEF   = 32;
    localparam int DEPTH_DEF    = 1024;
    localparam int ADDR_W_DEF   = 10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        UNPACK,
        HOLD
    } state_t;

endpackage

// File: rtl/rng_word_ram.sv
// Simple dual-port word store: one write port, one registered read port.
// Reads return the pre-write contents when both ports hit the same word.
module rng_word_ram #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic              in_range;

    assign in_range = {1'b0, rd_addr} < (ADDR_W+1)'(DEPTH);

    // Array contents survive reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (in_range) begin
            rd_data <= mem[rd_addr[PTR_W-1:0]];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/rng_word_buffer.sv
// Buffers conditioned RNG digests as a word-addressable store.
// Digests are unpacked MS word first; fill is one-shot or a refreshing ring.
module rng_word_buffer
    import rng_pkg::*;
#(
    parameter int DIGEST_W = DIGEST_W_DEF,
    parameter int WORD_W   = WORD_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                mode,
    input  logic                dig_valid,
    output logic                dig_ready,
    input  logic [DIGEST_W-1:0] dig_data,
    input  logic [ADDR_W-1:0]   ADDR,
    output logic [WORD_W-1:0]   DATA_OUT,
    output logic                ready
);

    localparam int N_SLICE = DIGEST_W / WORD_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = (N_SLICE > 1) ? $clog2(N_SLICE) : 1;

    state_t              state;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    slice_cnt;
    logic [DIGEST_W-1:0] shift_q;
    logic                ready_q;
    logic                last_slice;
    logic                ptr_wraps;
    logic                wr_en;
    logic [WORD_W-1:0]   wr_data;

    assign last_slice = slice_cnt == CNT_W'(N_SLICE - 1);
    assign ptr_wraps  = wr_ptr == PTR_W'(DEPTH - 1);
    assign dig_ready  = (state == LOAD) && enable;
    assign ready      = ready_q;

    // Gate the write on reset so an aborted digest leaves no trailing slice.
    assign wr_en   = (state == UNPACK) && !reset;
    assign wr_data = shift_q[DIGEST_W-1 -: WORD_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            slice_cnt <= '0;
            shift_q   <= '0;
            ready_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (dig_valid && dig_ready) begin
                        shift_q   <= dig_data;
                        slice_cnt <= '0;
                        state     <= UNPACK;
                    end
                end
                UNPACK: begin
                    shift_q   <= shift_q << WORD_W;
                    wr_ptr    <= wr_ptr + PTR_W'(1);
                    slice_cnt <= slice_cnt + CNT_W'(1);
                    if (last_slice) begin
                        slice_cnt <= '0;
                        if (ptr_wraps) begin
                            ready_q <= 1'b1;
                            state   <= mode ? LOAD : HOLD;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                HOLD: begin
                    state <= HOLD;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    rng_word_ram #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (ADDR),
        .rd_data (DATA_OUT)
    );

endmodule
